sram_axi_slave: RTL and testbench

SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

---
 rtl/sram_axi_pkg.sv | 31 +++
 rtl/sram_axi_addr_gen.sv | 54 +++++
 rtl/sram_axi_slave.sv | 249 ++++++++++++++++++++++++
 tb/tb_sram_axi_slave.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_pkg.sv
// sram_axi_pkg
//   Shared types and constants for the AXI-to-SRAM slave.
//   - state_t       : transaction FSM states
//   - RESP_*        : AXI response codes
//   - BURST_INCR    : the only burst type the slave models
//   - strb_to_bweb  : byte strobes -> active-low per-bit SRAM write enable
package sram_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // A set strobe bit enables (drives low) all eight bit-enables of its byte.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    bweb = {32{1'b1}};
    for (int k = 0; k < 4; k++) begin
      bweb[8*k +: 8] = {8{~strb[k]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/sram_axi_addr_gen.sv
// sram_axi_addr_gen
//   Word-index / beat-counter generator shared by the read and write paths.
//   Ports:
//     ACLK, ARESETn   clock, synchronous active-low reset
//     load            capture load_idx/load_len, clear beat counter
//     load_idx        starting SRAM word index
//     load_len        burst length minus one (AxLEN)
//     step            advance index (wraps modulo 2^MEM_AW) and beat counter
//     idx             current SRAM word index
//     beat            current beat number
//     last            current beat is the final one of the burst
module sram_axi_addr_gen #(
  parameter int MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              load,
  input  logic [MEM_AW-1:0] load_idx,
  input  logic [3:0]        load_len,
  input  logic              step,
  output logic [MEM_AW-1:0] idx,
  output logic [3:0]        beat,
  output logic              last
);

  logic [MEM_AW-1:0] idx_r;
  logic [3:0]        beat_r;
  logic [3:0]        len_r;

  // Index, beat and length registers; load has priority over step.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      idx_r  <= {MEM_AW{1'b0}};
      beat_r <= 4'd0;
      len_r  <= 4'd0;
    end else if (load) begin
      idx_r  <= load_idx;
      beat_r <= 4'd0;
      len_r  <= load_len;
    end else if (step) begin
      idx_r  <= idx_r + MEM_AW'(1);
      beat_r <= beat_r + 4'd1;
    end else begin
      idx_r  <= idx_r;
      beat_r <= beat_r;
      len_r  <= len_r;
    end
  end

  assign idx  = idx_r;
  assign beat = beat_r;
  assign last = (beat_r == len_r);

endmodule

// File: rtl/sram_axi_slave.sv
// sram_axi_slave
//   AXI slave in front of a single-port 32-bit SRAM, one transaction at a time.
//   Configuration macro: SRAM_AXI_BURST_EN -- when defined AxLEN 0..15 is
//   honoured; when undefined every transaction is a single beat.
//   Ports:
//     ACLK, ARESETn            clock, synchronous active-low reset
//     S_AW*, S_W*, S_B*        AXI write address / data / response channels
//     S_AR*, S_R*              AXI read address / data channels
//     SRAM_CEB/WEB/BWEB        active-low chip, write and per-bit write enables
//     SRAM_A, SRAM_DI          word address and write data
//     SRAM_DO                  read data, valid the cycle after a read access
module sram_axi_slave
  import sram_axi_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   S_AWID,
  input  logic [31:0]       S_AWADDR,
  input  logic [3:0]        S_AWLEN,
  input  logic [2:0]        S_AWSIZE,
  input  logic [1:0]        S_AWBURST,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [31:0]       S_WDATA,
  input  logic [3:0]        S_WSTRB,
  input  logic              S_WLAST,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  output logic [ID_W-1:0]   S_BID,
  output logic [1:0]        S_BRESP,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  input  logic [ID_W-1:0]   S_ARID,
  input  logic [31:0]       S_ARADDR,
  input  logic [3:0]        S_ARLEN,
  input  logic [2:0]        S_ARSIZE,
  input  logic [1:0]        S_ARBURST,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  output logic [ID_W-1:0]   S_RID,
  output logic [31:0]       S_RDATA,
  output logic [1:0]        S_RRESP,
  output logic              S_RLAST,
  output logic              S_RVALID,
  input  logic              S_RREADY,
  output logic              SRAM_CEB,
  output logic              SRAM_WEB,
  output logic [31:0]       SRAM_BWEB,
  output logic [MEM_AW-1:0] SRAM_A,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DO
);

  state_t            state_r, state_nxt_s;
  logic [ID_W-1:0]   id_r;
  logic              last_grant_wr_r;   // 1: write was served last
  logic [MEM_AW-1:0] a_last_r;          // address of the most recent access
  logic              wlast_early_r;     // WLAST seen before the final beat
  logic [1:0]        bresp_r;

  logic              ar_grant_s, aw_grant_s;
  logic              ar_rdy_s, aw_rdy_s, w_rdy_s;
  logic              rvalid_s, bvalid_s;
  logic              acc_s, we_s;
  logic              ag_load_s, ag_step_s, ag_last_s;
  logic [MEM_AW-1:0] ag_idx_s, ag_load_idx_s;
  logic [3:0]        ag_beat_s, ag_load_len_s;
  logic [3:0]        ar_len_s, aw_len_s;
  logic              unused_s;

  // Size, burst type and out-of-range address bits carry no information here.
  assign unused_s = ^{S_AWSIZE, S_ARSIZE, (S_AWBURST == BURST_INCR),
                      (S_ARBURST == BURST_INCR), S_AWADDR, S_ARADDR,
                      S_AWLEN, S_ARLEN, ag_beat_s};

`ifdef SRAM_AXI_BURST_EN
  assign ar_len_s = S_ARLEN;
  assign aw_len_s = S_AWLEN;
`else
  assign ar_len_s = 4'd0;
  assign aw_len_s = 4'd0;
`endif

  // Arbitration on a tie favours the channel that was not served last.
  always_comb begin
    ar_grant_s = 1'b0;
    aw_grant_s = 1'b0;
    if (S_ARVALID && S_AWVALID) begin
      if (last_grant_wr_r) begin
        ar_grant_s = 1'b1;
      end else begin
        aw_grant_s = 1'b1;
      end
    end else if (S_ARVALID) begin
      ar_grant_s = 1'b1;
    end else if (S_AWVALID) begin
      aw_grant_s = 1'b1;
    end else begin
      ar_grant_s = 1'b0;
      aw_grant_s = 1'b0;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_nxt_s = state_r;
    ar_rdy_s    = 1'b0;
    aw_rdy_s    = 1'b0;
    w_rdy_s     = 1'b0;
    rvalid_s    = 1'b0;
    bvalid_s    = 1'b0;
    acc_s       = 1'b0;
    we_s        = 1'b0;
    ag_load_s   = 1'b0;
    ag_step_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ar_grant_s) begin
          ar_rdy_s    = 1'b1;
          ag_load_s   = 1'b1;
          state_nxt_s = RD_ACC;
        end else if (aw_grant_s) begin
          aw_rdy_s    = 1'b1;
          ag_load_s   = 1'b1;
          state_nxt_s = WR_DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ACC: begin
        acc_s       = 1'b1;
        state_nxt_s = RD_DATA;
      end
      RD_DATA: begin
        // SRAM stays idle here; SRAM_DO holds the data across a stall.
        rvalid_s = 1'b1;
        if (S_RREADY) begin
          if (ag_last_s) begin
            state_nxt_s = IDLE;
          end else begin
            ag_step_s   = 1'b1;
            state_nxt_s = RD_ACC;
          end
        end else begin
          state_nxt_s = RD_DATA;
        end
      end
      WR_DATA: begin
        w_rdy_s = 1'b1;
        if (S_WVALID) begin
          acc_s     = 1'b1;
          we_s      = 1'b1;
          ag_step_s = 1'b1;
          if (ag_last_s) begin
            state_nxt_s = WR_RESP;
          end else begin
            state_nxt_s = WR_DATA;
          end
        end else begin
          state_nxt_s = WR_DATA;
        end
      end
      WR_RESP: begin
        bvalid_s = 1'b1;
        if (S_BREADY) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign ag_load_idx_s = ar_rdy_s ? S_ARADDR[MEM_AW+1:2] : S_AWADDR[MEM_AW+1:2];
  assign ag_load_len_s = ar_rdy_s ? ar_len_s : aw_len_s;

  sram_axi_addr_gen #(.MEM_AW(MEM_AW)) u_addr_gen (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .load     (ag_load_s),
    .load_idx (ag_load_idx_s),
    .load_len (ag_load_len_s),
    .step     (ag_step_s),
    .idx      (ag_idx_s),
    .beat     (ag_beat_s),
    .last     (ag_last_s)
  );

  // FSM state, transaction ID, arbitration history and write-response tracking.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r         <= IDLE;
      id_r            <= {ID_W{1'b0}};
      last_grant_wr_r <= 1'b1;
      a_last_r        <= {MEM_AW{1'b0}};
      wlast_early_r   <= 1'b0;
      bresp_r         <= RESP_OKAY;
    end else begin
      state_r <= state_nxt_s;
      if (ar_rdy_s) begin
        id_r            <= S_ARID;
        last_grant_wr_r <= 1'b0;
      end else if (aw_rdy_s) begin
        id_r            <= S_AWID;
        last_grant_wr_r <= 1'b1;
        wlast_early_r   <= 1'b0;
      end
      if (acc_s) begin
        a_last_r <= ag_idx_s;
      end
      // OKAY only when WLAST marks exactly the final beat and no earlier one.
      if (we_s) begin
        if (ag_last_s) begin
          bresp_r <= (S_WLAST && !wlast_early_r) ? RESP_OKAY : RESP_SLVERR;
        end else if (S_WLAST) begin
          wlast_early_r <= 1'b1;
        end
      end
    end
  end

  // Handshake readies and SRAM strobes are forced inactive while reset is held.
  assign S_ARREADY = ar_rdy_s & ARESETn;
  assign S_AWREADY = aw_rdy_s & ARESETn;
  assign S_WREADY  = w_rdy_s  & ARESETn;

  assign S_RVALID  = rvalid_s;
  assign S_RID     = id_r;
  assign S_RDATA   = SRAM_DO;
  assign S_RRESP   = RESP_OKAY;
  assign S_RLAST   = rvalid_s & ag_last_s;

  assign S_BVALID  = bvalid_s;
  assign S_BID     = id_r;
  assign S_BRESP   = bvalid_s ? bresp_r : RESP_OKAY;

  assign SRAM_CEB  = ~(acc_s & ARESETn);
  assign SRAM_WEB  = ~(acc_s & we_s & ARESETn);
  assign SRAM_BWEB = (acc_s & we_s & ARESETn) ? strb_to_bweb(S_WSTRB) : {32{1'b1}};
  assign SRAM_A    = acc_s ? ag_idx_s : a_last_r;
  assign SRAM_DI   = S_WDATA;

endmodule

// File: tb/tb_sram_axi_slave.sv
module tb_sram_axi_slave;

  localparam int ID_W   = 8;
  localparam int MEM_AW = 14;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [ID_W-1:0]   S_AWID;
  logic [31:0]       S_AWADDR;
  logic [3:0]        S_AWLEN;
  logic [2:0]        S_AWSIZE;
  logic [1:0]        S_AWBURST;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [31:0]       S_WDATA;
  logic [3:0]        S_WSTRB;
  logic              S_WLAST;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [ID_W-1:0]   S_BID;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [ID_W-1:0]   S_ARID;
  logic [31:0]       S_ARADDR;
  logic [3:0]        S_ARLEN;
  logic [2:0]        S_ARSIZE;
  logic [1:0]        S_ARBURST;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [ID_W-1:0]   S_RID;
  logic [31:0]       S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RLAST;
  logic              S_RVALID;
  logic              S_RREADY;
  logic              SRAM_CEB;
  logic              SRAM_WEB;
  logic [31:0]       SRAM_BWEB;
  logic [MEM_AW-1:0] SRAM_A;
  logic [31:0]       SRAM_DI;
  logic [31:0]       SRAM_DO;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  sram_axi_slave #(.ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY), .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
    .S_BREADY(S_BREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
    .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB),
    .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  // Behavioural SRAM with a backdoor write port and access counters.
  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  logic [31:0]       do_r = 32'h0;
  int                rd_acc = 0;
  int                wr_acc = 0;
  logic              bd_we = 1'b0;
  logic [MEM_AW-1:0] bd_addr = '0;
  logic [31:0]       bd_data = 32'h0;

  always @(posedge ACLK) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (!SRAM_CEB) begin
      if (!SRAM_WEB) begin
        mem[SRAM_A] <= (mem[SRAM_A] & SRAM_BWEB) | (SRAM_DI & ~SRAM_BWEB);
        wr_acc <= wr_acc + 1;
      end else begin
        do_r   <= mem[SRAM_A];
        rd_acc <= rd_acc + 1;
      end
    end
  end
  assign SRAM_DO = do_r;

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic poke(input logic [MEM_AW-1:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    cyc();
    bd_we   = 1'b0;
  endtask

  task automatic idle_inputs();
    S_AWID = '0; S_AWADDR = 32'h0; S_AWLEN = 4'd0; S_AWSIZE = 3'd2; S_AWBURST = 2'b01;
    S_AWVALID = 1'b0;
    S_WDATA = 32'h0; S_WSTRB = 4'hF; S_WLAST = 1'b0; S_WVALID = 1'b0;
    S_BREADY = 1'b0;
    S_ARID = '0; S_ARADDR = 32'h0; S_ARLEN = 4'd0; S_ARSIZE = 3'd2; S_ARBURST = 2'b01;
    S_ARVALID = 1'b0;
    S_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    idle_inputs();
    S_ARVALID = 1'b1;
    S_AWVALID = 1'b1;
    cyc();
    cyc();
    @(negedge ACLK);
    total++;
    if ({S_ARREADY, S_AWREADY, S_WREADY, S_RVALID, S_BVALID, S_RLAST} !== 6'b0) begin
      bad++;
      $display("FAIL reset_handshake: got %b want 000000",
               {S_ARREADY, S_AWREADY, S_WREADY, S_RVALID, S_BVALID, S_RLAST});
    end
    total++;
    if ({SRAM_CEB, SRAM_WEB} !== 2'b11 || SRAM_BWEB !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL reset_sram: got ceb/web=%b bweb=%h want 11 ffffffff",
               {SRAM_CEB, SRAM_WEB}, SRAM_BWEB);
    end
    total++;
    if (SRAM_A !== 14'd0) begin
      bad++;
      $display("FAIL reset_addr: got %h want 0", SRAM_A);
    end
    total++;
    if ({S_BRESP, S_RRESP} !== 4'b0 || S_RID !== 8'h0 || S_BID !== 8'h0) begin
      bad++;
      $display("FAIL reset_payload: got resp=%b rid=%h bid=%h want 0000 00 00",
               {S_BRESP, S_RRESP}, S_RID, S_BID);
    end
    @(posedge ACLK);
    #1;
    ARESETn   = 1'b1;
    S_ARVALID = 1'b0;
    S_AWVALID = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    poke(14'd4, 32'hDEAD_BEEF);
    S_ARID = 8'h12; S_ARADDR = 32'h0000_0010; S_ARLEN = 4'd0; S_ARVALID = 1'b1;
    S_RREADY = 1'b1;
    @(negedge ACLK);
    total++;
    if (S_ARREADY !== 1'b1) begin
      bad++; $display("FAIL rd_arready: got %b want 1", S_ARREADY);
    end
    cyc();
    S_ARVALID = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_RVALID !== 1'b0 || SRAM_CEB !== 1'b0 || SRAM_WEB !== 1'b1 || SRAM_A !== 14'd4) begin
      bad++;
      $display("FAIL rd_access: got rvalid=%b ceb=%b web=%b a=%h want 0 0 1 0004",
               S_RVALID, SRAM_CEB, SRAM_WEB, SRAM_A);
    end
    cyc();
    @(negedge ACLK);
    total++;
    if (S_RVALID !== 1'b1 || S_RDATA !== 32'hDEAD_BEEF || S_RID !== 8'h12 ||
        S_RLAST !== 1'b1 || S_RRESP !== 2'b00) begin
      bad++;
      $display("FAIL rd_beat: got v=%b d=%h id=%h last=%b resp=%b want 1 deadbeef 12 1 00",
               S_RVALID, S_RDATA, S_RID, S_RLAST, S_RRESP);
    end
    cyc();
    S_RREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_RVALID !== 1'b0 || SRAM_CEB !== 1'b1 || SRAM_A !== 14'd4) begin
      bad++;
      $display("FAIL rd_done: got rvalid=%b ceb=%b a=%h want 0 1 0004", S_RVALID, SRAM_CEB, SRAM_A);
    end
  endtask

  task automatic test_write();
    poke(14'd2, 32'h1122_3344);
    S_AWID = 8'h5A; S_AWADDR = 32'h0000_0008; S_AWLEN = 4'd0; S_AWVALID = 1'b1;
    S_WDATA = 32'hAABB_CCDD; S_WSTRB = 4'b0011; S_WLAST = 1'b1; S_WVALID = 1'b1;
    S_BREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_AWREADY !== 1'b1 || S_WREADY !== 1'b0 || SRAM_CEB !== 1'b1) begin
      bad++;
      $display("FAIL wr_aw: got awready=%b wready=%b ceb=%b want 1 0 1", S_AWREADY, S_WREADY, SRAM_CEB);
    end
    cyc();
    S_AWVALID = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_WREADY !== 1'b1 || SRAM_CEB !== 1'b0 || SRAM_WEB !== 1'b0 || SRAM_A !== 14'd2 ||
        SRAM_BWEB !== 32'hFFFF_0000 || SRAM_DI !== 32'hAABB_CCDD) begin
      bad++;
      $display("FAIL wr_access: got wready=%b ceb=%b web=%b a=%h bweb=%h di=%h want 1 0 0 0002 ffff0000 aabbccdd",
               S_WREADY, SRAM_CEB, SRAM_WEB, SRAM_A, SRAM_BWEB, SRAM_DI);
    end
    cyc();
    S_WVALID = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_BVALID !== 1'b1 || S_BRESP !== 2'b00 || S_BID !== 8'h5A || S_WREADY !== 1'b0) begin
      bad++;
      $display("FAIL wr_bresp: got bvalid=%b bresp=%b bid=%h wready=%b want 1 00 5a 0",
               S_BVALID, S_BRESP, S_BID, S_WREADY);
    end
    total++;
    if (mem[2] !== 32'h1122_CCDD) begin
      bad++; $display("FAIL wr_merge: got %h want 1122ccdd", mem[2]);
    end
    S_BREADY = 1'b1;
    cyc();
    S_BREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_BVALID !== 1'b0) begin
      bad++; $display("FAIL wr_bdone: got bvalid=%b want 0", S_BVALID);
    end
  endtask

  task automatic test_arbitration();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    cyc();
    ARESETn = 1'b1;
    S_ARID = 8'h01; S_ARADDR = 32'h0000_0010; S_ARLEN = 4'd0; S_ARVALID = 1'b1;
    S_AWID = 8'h02; S_AWADDR = 32'h0000_0020; S_AWLEN = 4'd0; S_AWVALID = 1'b1;
    S_RREADY = 1'b1; S_WVALID = 1'b0; S_BREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_ARREADY !== 1'b1 || S_AWREADY !== 1'b0) begin
      bad++; $display("FAIL arb_first: got ar=%b aw=%b want 1 0", S_ARREADY, S_AWREADY);
    end
    cyc();
    cyc();
    cyc();
    @(negedge ACLK);
    total++;
    if (S_AWREADY !== 1'b1 || S_ARREADY !== 1'b0) begin
      bad++; $display("FAIL arb_second: got ar=%b aw=%b want 0 1", S_ARREADY, S_AWREADY);
    end
    cyc();
    S_ARVALID = 1'b0; S_AWVALID = 1'b0; S_RREADY = 1'b0;
    S_WDATA = 32'hCAFE_F00D; S_WSTRB = 4'hF; S_WLAST = 1'b1; S_WVALID = 1'b1;
    cyc();
    S_WVALID = 1'b0;
    S_BREADY = 1'b1;
    @(negedge ACLK);
    total++;
    if (S_BVALID !== 1'b1 || S_BID !== 8'h02) begin
      bad++; $display("FAIL arb_wresp: got bvalid=%b bid=%h want 1 02", S_BVALID, S_BID);
    end
    cyc();
    S_BREADY = 1'b0;
  endtask

  task automatic test_burst_read();
    int nexp;
    int beat;
    int seen;
    int stall;
    int rd0;
    logic [31:0] held;
    logic [31:0] exp_d;
`ifdef SRAM_AXI_BURST_EN
    nexp = 4;
`else
    nexp = 1;
`endif
    for (int i = 0; i < 4; i++) begin
      poke(14'(8 + i), 32'hB000_0000 + 32'(i));
    end
    S_ARID = 8'h33; S_ARADDR = 32'h0000_0020; S_ARLEN = 4'd3; S_ARVALID = 1'b1;
    S_RREADY = 1'b0;
    @(negedge ACLK);
    total++;
    if (S_ARREADY !== 1'b1) begin
      bad++; $display("FAIL burst_arready: got %b want 1", S_ARREADY);
    end
    cyc();
    S_ARVALID = 1'b0;
    rd0   = rd_acc;
    beat  = 0;
    seen  = -1;
    stall = 0;
    held  = 32'h0;
    for (int c = 0; c < 60 && beat < nexp; c++) begin
      @(negedge ACLK);
      if (S_RVALID) begin
        if (seen != beat) begin
          seen  = beat;
          exp_d = 32'hB000_0000 + 32'(beat);
          total++;
          if (S_RDATA !== exp_d || S_RID !== 8'h33 || S_RLAST !== (beat == nexp - 1)) begin
            bad++;
            $display("FAIL burst_beat%0d: got d=%h id=%h last=%b want %h 33 %b",
                     beat, S_RDATA, S_RID, S_RLAST, exp_d, (beat == nexp - 1));
          end
        end
        if (beat == 1 && stall < 5) begin
          if (stall > 0) begin
            total++;
            if (S_RDATA !== held || SRAM_CEB !== 1'b1) begin
              bad++;
              $display("FAIL burst_stall: got d=%h ceb=%b want %h 1", S_RDATA, SRAM_CEB, held);
            end
          end
          held     = S_RDATA;
          S_RREADY = 1'b0;
          stall++;
        end else begin
          S_RREADY = 1'b1;
          beat++;
        end
      end else begin
        S_RREADY = 1'b0;
      end
      @(posedge ACLK);
      #1;
    end
    S_RREADY = 1'b0;
    total++;
    if (beat != nexp) begin
      bad++; $display("FAIL burst_timeout: got %0d beats want %0d", beat, nexp);
    end
    total++;
    if (rd_acc - rd0 != nexp) begin
      bad++; $display("FAIL burst_accesses: got %0d want %0d", rd_acc - rd0, nexp);
    end
    @(negedge ACLK);
    total++;
    if (S_RVALID !== 1'b0) begin
      bad++; $display("FAIL burst_end: got rvalid=%b want 0", S_RVALID);
    end
  endtask

  task automatic test_burst_write();
    logic [31:0] wd [2];
    logic        wl [2];
    int          w;
    int          wr0;
    logic        bseen;
    logic        hs;
    logic [1:0]  bresp_got;
    int          exp_n;
    logic [1:0]  exp_resp;
    logic [31:0] exp17;
`ifdef SRAM_AXI_BURST_EN
    exp_n = 2; exp_resp = 2'b10; exp17 = 32'h0202_0202;
`else
    exp_n = 1; exp_resp = 2'b00; exp17 = 32'h0000_0000;
`endif
    wd[0] = 32'h0101_0101; wl[0] = 1'b1;
    wd[1] = 32'h0202_0202; wl[1] = 1'b0;
    poke(14'd16, 32'h0);
    poke(14'd17, 32'h0);
    S_AWID = 8'h44; S_AWADDR = 32'h0000_0040; S_AWLEN = 4'd1; S_AWVALID = 1'b1;
    S_BREADY = 1'b0; S_WVALID = 1'b0; S_WSTRB = 4'hF;
    @(negedge ACLK);
    total++;
    if (S_AWREADY !== 1'b1) begin
      bad++; $display("FAIL bw_awready: got %b want 1", S_AWREADY);
    end
    cyc();
    S_AWVALID = 1'b0;
    wr0       = wr_acc;
    w         = 0;
    bseen     = 1'b0;
    bresp_got = 2'b11;
    for (int c = 0; c < 40 && !bseen; c++) begin
      if (w < 2) begin
        S_WVALID = 1'b1; S_WDATA = wd[w]; S_WLAST = wl[w];
      end else begin
        S_WVALID = 1'b0;
      end
      @(negedge ACLK);
      hs = S_WVALID && S_WREADY;
      if (S_BVALID) begin
        bseen     = 1'b1;
        bresp_got = S_BRESP;
      end
      @(posedge ACLK);
      #1;
      if (hs) w++;
    end
    S_WVALID = 1'b0;
    total++;
    if (!bseen) begin
      bad++; $display("FAIL bw_timeout: got no bvalid want bvalid");
    end
    total++;
    if (bresp_got !== exp_resp || S_BID !== 8'h44) begin
      bad++; $display("FAIL bw_bresp: got %b bid=%h want %b 44", bresp_got, S_BID, exp_resp);
    end
    total++;
    if (wr_acc - wr0 != exp_n) begin
      bad++; $display("FAIL bw_count: got %0d want %0d", wr_acc - wr0, exp_n);
    end
    total++;
    if (mem[16] !== 32'h0101_0101 || mem[17] !== exp17) begin
      bad++;
      $display("FAIL bw_data: got %h %h want 01010101 %h", mem[16], mem[17], exp17);
    end
    S_BREADY = 1'b1;
    cyc();
    S_BREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic stray;
    logic got;
    S_ARID = 8'h77; S_ARADDR = 32'h0000_0010; S_ARLEN = 4'd0; S_ARVALID = 1'b1;
    S_RREADY = 1'b0;
    cyc();
    S_ARVALID = 1'b0;
    cyc();
    @(negedge ACLK);
    total++;
    if (S_RVALID !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got rvalid=%b want 1", S_RVALID);
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    cyc();
    @(negedge ACLK);
    total++;
    if (S_RVALID !== 1'b0) begin
      bad++; $display("FAIL rst_mid_rvalid: got %b want 0", S_RVALID);
    end
    @(posedge ACLK);
    #1;
    ARESETn  = 1'b1;
    S_RREADY = 1'b1;
    stray    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      if (S_RVALID) stray = 1'b1;
      cyc();
    end
    total++;
    if (stray !== 1'b0) begin
      bad++; $display("FAIL rst_mid_stray: got rvalid seen=%b want 0", stray);
    end
    S_ARID = 8'h78; S_ARVALID = 1'b1;
    @(negedge ACLK);
    total++;
    if (S_ARREADY !== 1'b1) begin
      bad++; $display("FAIL rst_mid_arready: got %b want 1", S_ARREADY);
    end
    cyc();
    S_ARVALID = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge ACLK);
      if (S_RVALID) begin
        got = 1'b1;
        total++;
        if (S_RID !== 8'h78 || S_RDATA !== 32'hDEAD_BEEF) begin
          bad++; $display("FAIL rst_mid_reread: got id=%h d=%h want 78 deadbeef", S_RID, S_RDATA);
        end
      end
      cyc();
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL rst_mid_timeout: got no rvalid want rvalid");
    end
    S_RREADY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_burst_read();
    test_burst_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
